vga_timing_gen: RTL and testbench

Generates the raster scan for the display path: horizontal/vertical pixel counters, sync pulses, a visible-area flag, and line/frame strobes. It sits directly upstream of every `char_display` instance. `pixel_x` and `pixel_y` from this block drive the matching inputs of each character box. `video_on` gates the final pixel colour, and `hsync`/`vsync` go to the connector. Default timing is SVGA 800x600@60 (40 MHz pixel rate); the counter widths match `char_display` (11-bit x, 10-bit y).

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/wrap_counter.sv | 53 +++++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : SVGA 800x600@60 default raster timing and coordinate widths,
//            shared by the timing generator and the character boxes.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Coordinate widths; char_display uses the same widths for its inputs.
  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  // SVGA 800x600@60 Hz, 40 MHz pixel rate.
  localparam int unsigned SVGA_H_VISIBLE = 800;
  localparam int unsigned SVGA_H_FRONT   = 40;
  localparam int unsigned SVGA_H_SYNC    = 128;
  localparam int unsigned SVGA_H_BACK    = 88;
  localparam int unsigned SVGA_V_VISIBLE = 600;
  localparam int unsigned SVGA_V_FRONT   = 1;
  localparam int unsigned SVGA_V_SYNC    = 4;
  localparam int unsigned SVGA_V_BACK    = 23;

  // Length of one raster dimension: visible + front porch + sync + back porch.
  function automatic int unsigned raster_total(
    input int unsigned visible,
    input int unsigned front,
    input int unsigned sync,
    input int unsigned back
  );
    return visible + front + sync + back;
  endfunction

  localparam int unsigned SVGA_H_TOTAL =
    raster_total(SVGA_H_VISIBLE, SVGA_H_FRONT, SVGA_H_SYNC, SVGA_H_BACK);  // 1056
  localparam int unsigned SVGA_V_TOTAL =
    raster_total(SVGA_V_VISIBLE, SVGA_V_FRONT, SVGA_V_SYNC, SVGA_V_BACK);  // 628

endpackage : vga_pkg
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// ============================================================================
// Module   : wrap_counter
// Brief    : Enabled up-counter 0..MAX that wraps to 0, with terminal-count
//            flag and a look-ahead of the value it will hold after this edge.
//            Synchronous reset loads MAX so the first enable lands on 0.
// Revision : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int unsigned W   = 11,
  parameter int unsigned MAX = 1055
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Terminal count: the current value is the last one before wrapping.
  always_comb begin
    tc_o = (count_q == MAX_V);
  end

  // Next value: advance on enable, wrapping after MAX.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : (count_q + ONE_V);
    end
  end

  // Counter register; reset parks it at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= MAX_V;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule : wrap_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster scan generator: pixel counters, hsync/vsync, visible-area
//            flag, line/frame strobes. All outputs are registered together
//            from the next counter values, so they describe the same pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = SVGA_H_VISIBLE,
  parameter int unsigned H_FRONT   = SVGA_H_FRONT,
  parameter int unsigned H_SYNC    = SVGA_H_SYNC,
  parameter int unsigned H_BACK    = SVGA_H_BACK,
  parameter int unsigned V_VISIBLE = SVGA_V_VISIBLE,
  parameter int unsigned V_FRONT   = SVGA_V_FRONT,
  parameter int unsigned V_SYNC    = SVGA_V_SYNC,
  parameter int unsigned V_BACK    = SVGA_V_BACK,
  parameter logic        SYNC_POL  = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           line_start,
  output logic           frame_start
);

  localparam int unsigned H_TOTAL = raster_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = raster_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  // Phase boundaries, held at full counter width.
  localparam logic [X_W-1:0] H_VIS_END  = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_VISIBLE + H_FRONT);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_W-1:0] V_VIS_END  = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_VISIBLE + V_FRONT);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_tc, y_tc;
  logic           y_en;

  logic hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d;
  logic hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

  assign y_en = pix_ce & x_tc;

  wrap_counter #(
    .W   (X_W),
    .MAX (H_TOTAL - 1)
  ) u_x_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pix_ce),
    .count_o (x_q),
    .next_o  (x_d),
    .tc_o    (x_tc)
  );

  wrap_counter #(
    .W   (Y_W),
    .MAX (V_TOTAL - 1)
  ) u_y_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (y_en),
    .count_o (y_q),
    .next_o  (y_d),
    .tc_o    (y_tc)
  );

  // Decode sync/visible flags from the upcoming position; strobes fire only
  // on an advancing cycle whose upcoming x (and y) is 0.
  always_comb begin
    hsync_d       = ((x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (x_d < H_VIS_END) && (y_d < V_VIS_END);
    line_start_d  = pix_ce & x_tc;
    frame_start_d = pix_ce & x_tc & y_tc;
  end

  // Flag registers, loaded alongside the counters; reset values match the
  // parked back-porch position.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Self-checking bench. Two instances: SVGA defaults, and a small
//            raster with active-low sync so full frames fit in a short run.
//            Reference: a linear pixel index per frame, split into x/y.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // SVGA default instance
  localparam int HV0 = 800, HF0 = 40, HS0 = 128, HB0 = 88;
  localparam int VV0 = 600, VF0 = 1,  VS0 = 4,   VB0 = 23;
  localparam int HT0 = HV0 + HF0 + HS0 + HB0;
  localparam int VT0 = VV0 + VF0 + VS0 + VB0;
  localparam int FR0 = HT0 * VT0;
  // Small instance
  localparam int HV1 = 16, HF1 = 4, HS1 = 8, HB1 = 4;
  localparam int VV1 = 12, VF1 = 1, VS1 = 2, VB1 = 3;
  localparam int HT1 = HV1 + HF1 + HS1 + HB1;
  localparam int VT1 = VV1 + VF1 + VS1 + VB1;
  localparam int FR1 = HT1 * VT1;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic hs0, vs0, vo0, ls0, fs0;
  logic hs1, vs1, vo1, ls1, fs1;

  always #5 clk = ~clk;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0),
    .video_on(vo0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV1), .H_FRONT(HF1), .H_SYNC(HS1), .H_BACK(HB1),
    .V_VISIBLE(VV1), .V_FRONT(VF1), .V_SYNC(VS1), .V_BACK(VB1),
    .SYNC_POL(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1),
    .video_on(vo1), .line_start(ls1), .frame_start(fs1)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: linear index within the frame plus expected strobes.
  int p0, p1;
  bit els0, efs0, els1, efs1;
  // Period tracking (pix_ce cycles between strobes)
  int  since0, since1;
  bit  seen0, seen1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_inst(
    input string n, input int p,
    input int hv, input int hf, input int hs, input int ht,
    input int vv, input int vf, input int vs, input bit pol,
    input logic [10:0] ox, input logic [9:0] oy,
    input logic ohs, input logic ovs, input logic ovo,
    input logic ols, input logic ofs, input bit els, input bit efs
  );
    int x, y;
    bit in_hs, in_vs;
    x = p % ht;
    y = p / ht;
    in_hs = (x >= hv + hf) && (x < hv + hf + hs);
    in_vs = (y >= vv + vf) && (y < vv + vf + vs);
    chk({n, ".pixel_x"},     32'(ox),  32'(x));
    chk({n, ".pixel_y"},     32'(oy),  32'(y));
    chk({n, ".hsync"},       32'(ohs), 32'(in_hs ? pol : !pol));
    chk({n, ".vsync"},       32'(ovs), 32'(in_vs ? pol : !pol));
    chk({n, ".video_on"},    32'(ovo), 32'((x < hv) && (y < vv)));
    chk({n, ".line_start"},  32'(ols), 32'(els));
    chk({n, ".frame_start"}, 32'(ofs), 32'(efs));
  endtask

  // One clock: drive inputs, advance the reference, then check both DUTs.
  task automatic cyc(input bit r, input bit ce);
    reset  = r;
    pix_ce = ce;
    @(posedge clk);
    if (r) begin
      p0 = FR0 - 1; p1 = FR1 - 1;
      els0 = 0; efs0 = 0; els1 = 0; efs1 = 0;
      seen0 = 0; seen1 = 0; since0 = 0; since1 = 0;
    end else if (ce) begin
      p0 = (p0 + 1) % FR0;
      p1 = (p1 + 1) % FR1;
      els0 = (p0 % HT0 == 0); efs0 = (p0 == 0);
      els1 = (p1 % HT1 == 0); efs1 = (p1 == 0);
      since0++; since1++;
    end else begin
      els0 = 0; efs0 = 0; els1 = 0; efs1 = 0;
    end
    #1;
    check_inst("d0", p0, HV0, HF0, HS0, HT0, VV0, VF0, VS0, 1'b1,
               x0, y0, hs0, vs0, vo0, ls0, fs0, els0, efs0);
    check_inst("d1", p1, HV1, HF1, HS1, HT1, VV1, VF1, VS1, 1'b0,
               x1, y1, hs1, vs1, vo1, ls1, fs1, els1, efs1);
    if (!r && ls0 === 1'b1) begin
      if (seen0) chk("d0.line_period", 32'(since0), 32'(HT0));
      seen0 = 1; since0 = 0;
    end
    if (!r && fs1 === 1'b1) begin
      if (seen1) chk("d1.frame_period", 32'(since1), 32'(FR1));
      seen1 = 1; since1 = 0;
    end
  endtask

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b1;

    // Reset with pix_ce high: parked at the last back-porch position.
    repeat (3) cyc(1, 1);
    chk("rst.x", 32'(x0), 32'd1055);
    chk("rst.y", 32'(y0), 32'd627);
    chk("rst.hsync", 32'(hs0), 32'd0);

    // Release: first edge lands on (0,0) with both strobes.
    cyc(0, 1);
    chk("first.x", 32'(x0), 32'd0);
    chk("first.video_on", 32'(vo0), 32'd1);
    chk("first.frame_start", 32'(fs0), 32'd1);

    // A bit more than one full SVGA line (hsync window and line wrap).
    repeat (1100) cyc(0, 1);

    // Clock-enable gaps: 1,0,0,1 pattern.
    repeat (40) begin
      cyc(0, 1); cyc(0, 0); cyc(0, 0); cyc(0, 1);
    end

    // Randomised enable (~75% duty) with occasional random reset.
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom % 997) == 0, ($urandom % 4) != 0);
    end

    // Walk the SVGA instance into hsync at x=900, then reset there.
    for (int i = 0; i < 3000 && (p0 % HT0) != 900; i++) cyc(0, 1);
    chk("pre_rst.x", 32'(x0), 32'd900);
    chk("pre_rst.hsync", 32'(hs0), 32'd1);
    cyc(1, 1);
    chk("mid_rst.hsync", 32'(hs0), 32'd0);
    cyc(0, 1);
    chk("restart.x", 32'(x0), 32'd0);
    chk("restart.y", 32'(y0), 32'd0);

    // Several full frames on the small raster (frame period, vsync, wrap).
    repeat (3 * FR1 + 50) cyc(0, 1);

    // Random enable once more, no reset.
    for (int i = 0; i < 1500; i++) cyc(0, ($urandom % 2) == 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vga_timing_gen
`default_nettype wire
